// File: rtl/collision_unit_pkg.sv
// rtl/collision_unit_pkg.sv - shared game constants and collision FSM state encoding
package collision_unit_pkg;
   localparam int STEP_SIZE = 32;
   localparam int POSITIONS = 640 / STEP_SIZE;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SNAP      = 3'd1,
      ST_SCAN      = 3'd2,
      ST_RESOLVE   = 3'd3,
      ST_COOLDOWN  = 3'd4,
      ST_GAME_OVER = 3'd5
   } state_t;
endpackage

// File: rtl/lane_overlap.sv
// rtl/lane_overlap.sv - combinational test of whether one car covers the frog's cell
module lane_overlap #(
   parameter int POSITIONS = collision_unit_pkg::POSITIONS
) (
   input  logic [4:0] car_pos,
   input  logic [1:0] car_len,
   input  logic [9:0] car_y,
   input  logic [4:0] frog_pos,
   input  logic [9:0] frog_y,
   output logic       overlap
);
   logic [5:0] w_sum  [4];
   logic [5:0] w_cell [4];
   logic [3:0] w_len_ok;
   logic [3:0] w_match;

   // Cell k is occupied when k <= car_len; written as a thermometer code.
   assign w_len_ok = {car_len == 2'd3, car_len[1], |car_len, 1'b1};

   for (genvar k = 0; k < 4; k++) begin : g_cell
      assign w_sum[k]   = {1'b0, car_pos} + 6'(k);
      assign w_cell[k]  = (w_sum[k] >= 6'(POSITIONS)) ? w_sum[k] - 6'(POSITIONS) : w_sum[k];
      assign w_match[k] = w_len_ok[k] && (w_cell[k] == {1'b0, frog_pos});
   end

   assign overlap = (car_y == frog_y) && (|w_match);
endmodule

// File: rtl/collision_unit.sv
// rtl/collision_unit.sv - sequential car/frog collision scan with lives and cooldown
module collision_unit #(
   parameter int NUM_CARS       = 8,
   parameter int POSITIONS      = collision_unit_pkg::POSITIONS,
   parameter int LIVES_INIT     = 3,
   parameter int COOLDOWN_TICKS = 60
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_enable,
   input  logic [NUM_CARS*5-1:0] car_pos_flat,
   input  logic [NUM_CARS*10-1:0] car_y_flat,
   input  logic [NUM_CARS*2-1:0] car_len_flat,
   input  logic [4:0]            frog_pos,
   input  logic [9:0]            frog_y,
   input  logic                  restart,
   output logic                  hit,
   output logic [1:0]            lives,
   output logic                  invuln,
   output logic                  game_over,
   output logic                  busy
);
   import collision_unit_pkg::*;

   localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
   localparam int CD_W  = $clog2(COOLDOWN_TICKS + 1);

   state_t                r_state, w_state_next;
   logic [IDX_W-1:0]      r_idx;
   logic [CD_W-1:0]       r_cd;
   logic                  r_hit_flag;
   logic                  r_hit;
   logic [1:0]            r_lives;
   logic                  r_invuln, r_go, r_busy;
   logic [NUM_CARS*5-1:0] r_snap_pos;
   logic [NUM_CARS*10-1:0] r_snap_y;
   logic [NUM_CARS*2-1:0] r_snap_len;
   logic [4:0]            r_snap_fpos;
   logic [9:0]            r_snap_fy;
   logic                  w_overlap;

   lane_overlap #(.POSITIONS(POSITIONS)) u_lane_overlap (
      .car_pos  (r_snap_pos[int'(r_idx)*5 +: 5]),
      .car_len  (r_snap_len[int'(r_idx)*2 +: 2]),
      .car_y    (r_snap_y[int'(r_idx)*10 +: 10]),
      .frog_pos (r_snap_fpos),
      .frog_y   (r_snap_fy),
      .overlap  (w_overlap)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:      if (clk_enable) w_state_next = ST_SNAP;
         ST_SNAP:      w_state_next = ST_SCAN;
         ST_SCAN:      if (r_idx == IDX_W'(NUM_CARS - 1)) w_state_next = ST_RESOLVE;
         ST_RESOLVE: begin
            if (!r_hit_flag)          w_state_next = ST_IDLE;
            else if (r_lives == 2'd1) w_state_next = ST_GAME_OVER;
            else                      w_state_next = ST_COOLDOWN;
         end
         ST_COOLDOWN:  if (clk_enable && r_cd == CD_W'(1)) w_state_next = ST_IDLE;
         ST_GAME_OVER: if (restart) w_state_next = ST_IDLE;
         default:      w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx       <= '0;
         r_cd        <= '0;
         r_hit_flag  <= 1'b0;
         r_hit       <= 1'b0;
         r_lives     <= 2'(LIVES_INIT);
         r_invuln    <= 1'b0;
         r_go        <= 1'b0;
         r_busy      <= 1'b0;
         r_snap_pos  <= '0;
         r_snap_y    <= '0;
         r_snap_len  <= '0;
         r_snap_fpos <= '0;
         r_snap_fy   <= '0;
      end else begin
         r_hit    <= 1'b0;
         // Status flags decode the upcoming state so they line up with it.
         r_busy   <= (w_state_next == ST_SNAP) || (w_state_next == ST_SCAN) ||
                     (w_state_next == ST_RESOLVE);
         r_invuln <= (w_state_next == ST_COOLDOWN);
         r_go     <= (w_state_next == ST_GAME_OVER);
         case (r_state)
            ST_IDLE: begin
               if (clk_enable) begin
                  r_snap_pos  <= car_pos_flat;
                  r_snap_y    <= car_y_flat;
                  r_snap_len  <= car_len_flat;
                  r_snap_fpos <= frog_pos;
                  r_snap_fy   <= frog_y;
                  r_hit_flag  <= 1'b0;
                  r_idx       <= '0;
               end
            end
            ST_SCAN: begin
               r_hit_flag <= r_hit_flag | w_overlap;
               r_idx      <= r_idx + IDX_W'(1);
            end
            ST_RESOLVE: begin
               if (r_hit_flag) begin
                  r_hit   <= 1'b1;
                  r_lives <= r_lives - 2'd1;
                  if (r_lives != 2'd1) r_cd <= CD_W'(COOLDOWN_TICKS);
               end
            end
            ST_COOLDOWN: if (clk_enable) r_cd <= r_cd - CD_W'(1);
            ST_GAME_OVER: if (restart) r_lives <= 2'(LIVES_INIT);
            default: ;
         endcase
      end
   end

   assign hit       = r_hit;
   assign lives     = r_lives;
   assign invuln    = r_invuln;
   assign game_over = r_go;
   assign busy      = r_busy;
endmodule
